if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and reset.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
  RESET_PC    32'h0000_0000   fetch address after reset
  FIFO_DEPTH  2               instruction buffer entries, power of two, >=2
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk            in   1   clock
  reset          in   1   async active-low reset
  imem_req       out  1   fetch request valid
  imem_addr      out  32  fetch word address, bits [1:0] always 0
  imem_gnt       in   1   request accepted this cycle
  imem_rvalid    in   1   response data valid
  imem_rdata     in   32  fetched instruction
  inst_valid     out  1   inst/pc/pc4 valid toward decode
  inst_ready     in   1   decode accepts head entry
  inst           out  32  instruction to decode
  pc             out  32  address of inst
  pc4            out  32  pc + 4 (decode's branch adder base)
  redirect       in   1   branch/jump taken; refetch
  redirect_addr  in   32  new fetch address, bits [1:0] ignored

Function
REQ-004 The FSM SHALL have states IDLE, REQ, WAIT and DRAIN, with at most one request outstanding.
REQ-005 IDLE SHALL go to REQ when count + outstanding < FIFO_DEPTH; otherwise it SHALL stay in IDLE.
REQ-006 REQ SHALL drive imem_req=1 and imem_addr=fetch_pc; on imem_gnt it SHALL go to WAIT and set fetch_pc <= fetch_pc + 4.
REQ-007 In REQ without gnt, imem_req SHALL stay high; imem_addr SHALL stay stable except on redirect, which retargets it on the next cycle.
REQ-008 In WAIT, imem_rvalid SHALL push {pc, imem_rdata} into the buffer, and the FSM SHALL go to REQ if space remains, else to IDLE.
REQ-009 The issue gating SHALL ensure a push never meets a full buffer.
REQ-010 fetch_pc SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.
REQ-011 inst_valid SHALL equal buffer non-empty; inst, pc and pc4 SHALL come from the buffer head.
REQ-012 When the buffer is empty, inst SHALL be 32'h0000_0013 (NOP), and pc and pc4 SHALL be 0.
REQ-013 The head SHALL pop when inst_valid && inst_ready.
REQ-014 Push and pop SHALL be allowed in the same cycle.
REQ-015 Latency from rvalid to inst_valid SHALL be 1 cycle, with no combinational bypass.
REQ-016 Redirect SHALL have highest priority: fetch_pc <= {redirect_addr[31:2],2'b00}, the buffer is flushed, and inst_valid=0 next cycle.
REQ-017 A redirect in WAIT without rvalid, or in REQ with gnt the same cycle, SHALL go to DRAIN.
REQ-018 DRAIN SHALL discard the next rvalid and then go to REQ.
REQ-019 A redirect coincident with rvalid in WAIT SHALL discard that data and go directly to REQ.
REQ-020 A redirect in IDLE, or in REQ without gnt, SHALL go to REQ.
REQ-021 A redirect in DRAIN SHALL update fetch_pc and stay in DRAIN.
REQ-022 A pop coincident with redirect SHALL be ignored, because the flush wins.

Reset
REQ-023 While reset=0, the block SHALL hold state=IDLE, fetch_pc=RESET_PC, buffer empty, outstanding=0, imem_req=0, imem_addr=0, inst_valid=0, inst=NOP, pc=0, pc4=0.
REQ-024 The first imem_req SHALL assert 1 cycle after reset deasserts (IDLE to REQ).
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction; a late rvalid arriving in IDLE after reset SHALL be ignored.

Structure
REQ-026 A shared package if_pkg SHALL hold the FSM state enum, the NOP constant 32'h0000_0013 and the default RESET_PC.
REQ-027 The buffer SHALL be a sub-module if_fifo (parameterized depth and width = 64 bits {pc, inst}) with push/pop/flush inputs, a count output, and an asynchronous active-low reset.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  Reset release, gnt=1, rvalid one cycle after gnt, inst_ready=1 -> imem_addr 0, 4, 8 on successive requests; inst/pc/pc4 stream in order with pc4=pc+4.
  inst_ready=0 with FIFO_DEPTH=2 -> exactly two requests issued, then imem_req=0 until a pop; no data lost.
  Redirect to 32'h0000_0103 while in WAIT -> the next rvalid is dropped (DRAIN), the next imem_addr=32'h0000_0100, and inst_valid=0 until the new data arrives.
  Redirect coincident with rvalid -> the data is not pushed, the FSM goes directly to REQ at the redirect target, and the buffer is empty next cycle.
  RESET_PC=32'hFFFF_FFFC -> the second request address is 32'h0000_0000.
  gnt held low 5 cycles, then redirect -> imem_req stays high throughout and imem_addr changes only on the cycle after the redirect.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } if_state_e;

  // Instruction presented to decode when nothing is buffered (addi x0, x0, 0).
  localparam logic [31:0] NopInst = 32'h0000_0013;

  // Default fetch address after reset.
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

endpackage

// File: rtl/if_fifo.sv
// Instruction buffer: small circular FIFO with a single-cycle flush.
module if_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne = 1;
  localparam logic [AW:0]   CntOne = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  // Flush dominates: nothing is written or consumed in a flush cycle.
  assign empty   = (count_q == '0);
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one-outstanding memory fetch FSM feeding a small buffer.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DefaultResetPc,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic        redirect,
  input  logic [31:0] redirect_addr
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  if_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] redirect_pc;
  logic [CntW-1:0] fifo_count;
  logic [63:0] head;
  logic        fifo_empty, outstanding, push, pop, issue_ok, space_after_push;

  assign outstanding = (state_q == StWait) || (state_q == StDrain);
  assign redirect_pc = {redirect_addr[31:2], 2'b00};

  // Redirect flushes the buffer, so it also suppresses this cycle's push and pop.
  assign push = (state_q == StWait) && imem_rvalid && !redirect;
  assign pop  = inst_valid && inst_ready && !redirect;

  // Issue only when the reply is guaranteed a free slot.
  assign issue_ok         = (32'(fifo_count) + 32'(outstanding)) < FIFO_DEPTH;
  assign space_after_push = (32'(fifo_count) + 32'd1 - 32'(pop)) < FIFO_DEPTH;

  // Next-state, fetch address and in-flight request address.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    unique case (state_q)
      StIdle: begin
        if (redirect || issue_ok) state_d = StReq;
      end
      StReq: begin
        if (imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = redirect ? StDrain : StWait;
        end
      end
      StWait: begin
        if (redirect)         state_d = imem_rvalid ? StReq : StDrain;
        else if (imem_rvalid) state_d = space_after_push ? StReq : StIdle;
      end
      StDrain: begin
        if (imem_rvalid) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
    if (redirect) fetch_pc_d = redirect_pc;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({req_pc_q, imem_rdata}),
    .pop   (pop),
    .flush (redirect),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign imem_req   = (state_q == StReq);
  assign imem_addr  = imem_req ? fetch_pc_q : '0;
  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? NopInst : head[31:0];
  assign pc         = fifo_empty ? '0 : head[63:32];
  assign pc4        = fifo_empty ? '0 : head[63:32] + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory responder, program-order stream model, directed scenarios.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk, reset;
  logic imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, inst, pc, pc4, redirect_addr;
  // Second instance with a reset PC at the top of the address space.
  logic imem_req2, gnt2, rvalid2, inst_valid2, ready2, redirect2;
  logic [31:0] imem_addr2, rdata2, inst2, pc2, pc4_2, redirect_addr2;

  int n_tests = 0;
  int n_fail  = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc), .pc4(pc4),
    .redirect(redirect), .redirect_addr(redirect_addr)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_gnt(gnt2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .inst_valid(inst_valid2), .inst_ready(ready2), .inst(inst2), .pc(pc2), .pc4(pc4_2),
    .redirect(redirect2), .redirect_addr(redirect_addr2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: every word is a distinct function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F13;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory model state
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        gnt_seen = 1'b0, gnt2_seen = 1'b0;
  logic [31:0] gnt_addr = '0, gnt2_addr = '0, mem_addr = '0;

  // Memory responder: answers a grant after mem_lat cycles (1 = the very next cycle).
  initial begin
    imem_rvalid = 1'b0; imem_rdata = '0; rvalid2 = 1'b0; rdata2 = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (gnt_seen) begin
        mem_cnt  = mem_lat;
        mem_addr = gnt_addr;
        gnt_seen = 1'b0;
      end
      if (mem_cnt == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_cnt     = 0;
      end else if (mem_cnt > 1) begin
        mem_cnt--;
      end
      rvalid2   = gnt2_seen;
      rdata2    = mem_word(gnt2_addr);
      gnt2_seen = 1'b0;
    end
  end

  // Model: decode must see a gap-free program-order stream from the reset PC or the last
  // redirect target, with inst equal to memory contents at pc.
  logic [31:0] exp_pc = '0;
  int          n_gnt = 0, n_pop = 0;
  logic [31:0] glog[$];
  logic        rst_prev = 1'b0, req_prev = 1'b0, gnt_prev = 1'b0, redir_prev = 1'b0;
  logic [31:0] tgt_prev = '0, addr_prev = '0;
  logic [31:0] g2_addr[2], p2_pc[2], p2_pc4[2];
  int          n_g2 = 0, n_p2 = 0;

  // Per-cycle compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, NOP);
      chk("rst_pc", pc, 32'd0);
      chk("rst_pc4", pc4, 32'd0);
      exp_pc = 32'h0;
    end else begin
      chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (!inst_valid) begin
        chk("empty_inst_nop", inst, NOP);
        chk("empty_pc", pc, 32'd0);
        chk("empty_pc4", pc4, 32'd0);
      end
      if (redir_prev) chk("flush_after_redirect", 32'(inst_valid), 32'd0);
      if (rst_prev && req_prev && !gnt_prev) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_stable", imem_addr, redir_prev ? tgt_prev : addr_prev);
      end
      if (imem_req && imem_gnt) begin
        chk("one_outstanding", 32'(mem_cnt), 32'd0);
        gnt_seen = 1'b1;
        gnt_addr = imem_addr;
        n_gnt++;
        glog.push_back(imem_addr);
      end
      if (redirect) begin
        exp_pc = {redirect_addr[31:2], 2'b00};
      end else if (inst_valid && inst_ready) begin
        chk("stream_pc", pc, exp_pc);
        chk("stream_inst", inst, mem_word(exp_pc));
        chk("stream_pc4", pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_pop++;
      end
      if (imem_req2) begin
        gnt2_seen = 1'b1;
        gnt2_addr = imem_addr2;
        if (n_g2 < 2) begin g2_addr[n_g2] = imem_addr2; n_g2++; end
      end
      if (inst_valid2 && n_p2 < 2) begin
        p2_pc[n_p2] = pc2; p2_pc4[n_p2] = pc4_2; n_p2++;
      end
    end
    rst_prev   = reset;
    req_prev   = imem_req;
    gnt_prev   = imem_gnt;
    redir_prev = reset && redirect;
    tgt_prev   = {redirect_addr[31:2], 2'b00};
    addr_prev  = imem_addr;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int          p0, bad;
  logic [31:0] a0;

  initial begin
    reset = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_addr = '0;
    gnt2 = 1'b1; ready2 = 1'b1; redirect2 = 1'b0; redirect_addr2 = '0;
    repeat (3) tick();

    // S1: streaming from reset, addresses 0, 4, 8 and one-cycle rvalid-to-valid latency
    glog.delete();
    reset = 1'b1;
    chk("s1_idle_at_release", 32'(imem_req), 32'd0);
    tick();
    chk("s1_first_req", 32'(imem_req), 32'd1);
    chk("s1_first_addr", imem_addr, 32'h0);
    tick();
    chk("s1_rvalid", 32'(imem_rvalid), 32'd1);
    chk("s1_no_bypass", 32'(inst_valid), 32'd0);
    tick();
    chk("s1_valid", 32'(inst_valid), 32'd1);
    chk("s1_pc", pc, 32'h0);
    chk("s1_inst", inst, 32'h5A5A_0F13);
    chk("s1_pc4", pc4, 32'h4);
    repeat (10) tick();
    chk("s1_gnt_count", 32'(glog.size() >= 3), 32'd1);
    if (glog.size() >= 3) begin
      chk("s1_addr1", glog[1], 32'h4);
      chk("s1_addr2", glog[2], 32'h8);
    end

    // S2: decode stalled -> exactly FIFO_DEPTH requests, then nothing until a pop
    reset = 1'b0;
    repeat (2) tick();
    n_gnt = 0;
    inst_ready = 1'b0;
    reset = 1'b1;
    repeat (12) tick();
    chk("s2_two_reqs", 32'(n_gnt), 32'd2);
    chk("s2_req_low", 32'(imem_req), 32'd0);
    chk("s2_head_pc", pc, 32'h0);
    p0 = n_pop;
    inst_ready = 1'b1;
    repeat (10) tick();
    chk("s2_resumed", 32'(n_pop - p0 >= 3), 32'd1);

    // S3: redirect while waiting without rvalid -> stale reply drained
    mem_lat = 3;
    for (int i = 0; i < 30 && mem_cnt != 2; i++) tick();
    chk("s3_in_wait", 32'(mem_cnt), 32'd2);
    redirect = 1'b1; redirect_addr = 32'h0000_0103;
    glog.delete();
    tick();
    redirect = 1'b0;
    mem_lat = 1;
    bad = 0;
    for (int i = 0; i < 30 && glog.size() == 0; i++) begin
      if (inst_valid) bad++;
      tick();
    end
    chk("s3_gnt_seen", 32'(glog.size()), 32'd1);
    if (glog.size() > 0) chk("s3_next_addr", glog[0], 32'h0000_0100);
    chk("s3_valid_low", 32'(bad), 32'd0);
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    chk("s3_new_pc", pc, 32'h0000_0100);
    repeat (4) tick();

    // S4: redirect coincident with rvalid -> data dropped, straight to REQ
    for (int i = 0; i < 20 && !imem_rvalid; i++) tick();
    chk("s4_rvalid", 32'(imem_rvalid), 32'd1);
    redirect = 1'b1; redirect_addr = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    chk("s4_empty", 32'(inst_valid), 32'd0);
    chk("s4_req", 32'(imem_req), 32'd1);
    chk("s4_addr", imem_addr, 32'h0000_0300);
    repeat (6) tick();

    // S6: grant withheld 5 cycles, then redirect retargets only on the next cycle
    imem_gnt = 1'b0;
    for (int i = 0; i < 10 && !imem_req; i++) tick();
    chk("s6_req", 32'(imem_req), 32'd1);
    a0 = imem_addr;
    bad = 0;
    repeat (5) begin
      tick();
      if (!imem_req || imem_addr !== a0) bad++;
    end
    chk("s6_held", 32'(bad), 32'd0);
    redirect = 1'b1; redirect_addr = 32'h0000_0402;
    tick();
    redirect = 1'b0;
    chk("s6_req_after", 32'(imem_req), 32'd1);
    chk("s6_addr_after", imem_addr, 32'h0000_0400);
    imem_gnt = 1'b1;
    repeat (6) tick();

    // S7: reset mid-transaction; the late reply lands while idle and is ignored
    mem_lat = 3;
    for (int i = 0; i < 30 && mem_cnt != 2; i++) tick();
    chk("s7_in_wait", 32'(mem_cnt), 32'd2);
    reset = 1'b0;
    repeat (2) tick();
    chk("s7_late_rvalid", 32'(imem_rvalid), 32'd1);
    mem_lat = 1;
    reset = 1'b1;
    chk("s7_idle", 32'(imem_req), 32'd0);
    tick();
    chk("s7_req", 32'(imem_req), 32'd1);
    chk("s7_addr", imem_addr, 32'h0);
    chk("s7_empty", 32'(inst_valid), 32'd0);
    p0 = n_pop;
    repeat (8) tick();
    chk("s7_stream", 32'(n_pop - p0 >= 2), 32'd1);

    // S5: wrap of the fetch address at the top of memory (second instance)
    chk("s5_n_gnt", 32'(n_g2), 32'd2);
    chk("s5_n_pop", 32'(n_p2), 32'd2);
    if (n_g2 == 2) begin
      chk("s5_addr0", g2_addr[0], 32'hFFFF_FFFC);
      chk("s5_addr1", g2_addr[1], 32'h0000_0000);
    end
    if (n_p2 == 2) begin
      chk("s5_pc0", p2_pc[0], 32'hFFFF_FFFC);
      chk("s5_pc4_0", p2_pc4[0], 32'h0000_0000);
      chk("s5_pc1", p2_pc[1], 32'h0000_0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
